// File: rtl/divide_unit.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One operation per start; 32 iterations; one-cycle done pulse with registered result.
//
// state  | meaning
// IDLE   | waiting for div_en; result holds last value
// CALC   | one restoring-division iteration per cycle
// DONE   | div_done high for one cycle; result valid
module divide_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            div_en,
  input  logic            flush,
  input  logic [1:0]      div,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            div_done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            is_rem_q, neg_q_q, neg_r_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;

  logic            op_signed, a_neg, b_neg, div_zero, ovf, special, accept, last;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic            ge;
  logic [XLEN-1:0] next_rem, next_quo, fix_src, fixed;
  logic            fix_neg;

  assign op_signed = ~div[0];
  assign a_neg     = op_signed & dividend[XLEN-1];
  assign b_neg     = op_signed & divisor[XLEN-1];
  assign a_mag     = a_neg ? -dividend : dividend;
  assign b_mag     = b_neg ? -divisor : divisor;
  assign div_zero  = (divisor == '0);
  assign ovf       = op_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor);
  assign special   = div_zero | ovf;
  // Overflow DIV returns the dividend itself (most negative value)
  assign special_res = div_zero ? (div[1] ? dividend : '1)
                                : (div[1] ? '0 : dividend);
  assign accept    = (state_q == S_IDLE) & div_en & ~flush;
  assign last      = (cnt_q == CW'(XLEN-1));

  // Borrow out of the 33-bit trial subtract decides the quotient bit
  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign diff     = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign ge       = ~diff[XLEN+1];
  assign next_rem = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign next_quo = {quo_q[XLEN-2:0], ge};

  assign fix_src = is_rem_q ? next_rem : next_quo;
  assign fix_neg = is_rem_q ? neg_r_q : neg_q_q;
  assign fixed   = fix_neg ? -fix_src : fix_src;

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC:  if (flush) state_d = S_IDLE;
               else if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    div_done = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result   <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      is_rem_q <= div[1];
      neg_q_q  <= a_neg ^ b_neg;
      neg_r_q  <= a_neg;
      rem_q    <= '0;
      quo_q    <= a_mag;
      dvs_q    <= b_mag;
      if (special) result <= special_res;
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q + CW'(1);
      rem_q <= next_rem;
      quo_q <= next_quo;
      if (last && !flush) result <= fixed;
    end
  end

endmodule

// File: tb/tb_divide_unit.sv
// Self-checking bench for divide_unit: directed cases, timing scenarios and
// randomized ops compared against a plain-arithmetic reference.
module tb_divide_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        div_en = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  div = 2'd0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, div_done;
  logic [31:0] result;

  int vectors = 0;
  int errors  = 0;

  divide_unit #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .div_en(div_en), .flush(flush), .div(div),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .div_done(div_done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RISC-V M-extension semantics from plain arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    case (op)
      2'd0:    return 32'(sa / sb);
      2'd1:    return a / b;
      2'd2:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv);
    int lat, exp_lat;
    logic [31:0] got;
    exp_lat = (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    div_en = 1'b1; div = op; dividend = a; divisor = b;
    step();
    div_en = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
    end
    lat = 1;
    while (div_done !== 1'b1 && lat < 40) begin
      dividend = $urandom; divisor = $urandom; div = 2'($urandom);
      step();
      lat++;
    end
    got = result;
    vectors++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    vectors++;
    if (got !== expv) begin
      errors++; $display("FAIL %s result: got %h want %h (a=%h b=%h op=%0d)",
                         name, got, expv, a, b, op);
    end
    step();
    vectors++;
    if (busy !== 1'b0 || div_done !== 1'b0) begin
      errors++; $display("FAIL %s after_done: busy=%b done=%b want 0/0", name, busy, div_done);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    vectors++;
    if (busy !== 1'b0 || div_done !== 1'b0 || result !== 32'h0) begin
      errors++; $display("FAIL reset: busy=%b done=%b result=%h want 0/0/0", busy, div_done, result);
    end
  endtask

  task automatic test_directed();
    run_op("divu_max_3",  2'd1, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555);
    run_op("remu_7_3",    2'd3, 32'd7,         32'd3,         32'd1);
    run_op("div_m7_2",    2'd0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("rem_m7_2",    2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("div_7_m2",    2'd0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_op("rem_7_m2",    2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1);
    run_op("divu_5_0",    2'd1, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op("remu_5_0",    2'd3, 32'd5,         32'd0,         32'd5);
    run_op("div_ovf",     2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_op("rem_m5_0",    2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB);
    run_op("divu_ovfpat", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 16);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      run_op("random", op, a, b, model(op, a, b));
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] a, b, expv, got;
    int done_cnt, done_at;
    a = $urandom;
    b = $urandom_range(3, 50000);
    expv = model(2'd1, a, b);
    div_en = 1'b1; div = 2'd1; dividend = a; divisor = b;
    step();
    done_cnt = 0; done_at = 0; got = '0;
    for (int c = 1; c <= 40; c++) begin
      if (div_done === 1'b1) begin done_cnt++; done_at = c; got = result; end
      div_en = (c == 5);
      dividend = $urandom; divisor = $urandom; div = 2'($urandom);
      step();
    end
    div_en = 1'b0;
    vectors++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL ignored_start done_count: got %0d want 1", done_cnt);
    end
    vectors++;
    if (done_at !== 33) begin
      errors++; $display("FAIL ignored_start done_cycle: got %0d want 33", done_at);
    end
    vectors++;
    if (got !== expv) begin
      errors++; $display("FAIL ignored_start result: got %h want %h", got, expv);
    end
  endtask

  task automatic test_flush();
    logic [31:0] prior, got;
    int done_at;
    bit held;
    run_op("flush_prior", 2'd3, 32'd7, 32'd3, 32'd1);
    prior = 32'd1;
    div_en = 1'b1; div = 2'd0; dividend = 32'd1000; divisor = 32'd7;
    step();
    div_en = 1'b0;
    for (int c = 1; c < 10; c++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush busy: got %b want 0", busy);
    end
    div_en = 1'b1; div = 2'd1; dividend = 32'd100; divisor = 32'd7;
    step();
    div_en = 1'b0;
    done_at = 0; held = 1'b1; got = '0;
    for (int c = 12; c <= 50; c++) begin
      if (div_done === 1'b1 && done_at == 0) begin done_at = c; got = result; end
      if (done_at == 0 && result !== prior) held = 1'b0;
      step();
    end
    vectors++;
    if (!held) begin
      errors++; $display("FAIL flush result_hold: got changed want %h", prior);
    end
    vectors++;
    if (done_at !== 44) begin
      errors++; $display("FAIL flush next_done_cycle: got %0d want 44", done_at);
    end
    vectors++;
    if (got !== 32'd14) begin
      errors++; $display("FAIL flush next_result: got %h want %h", got, 32'd14);
    end
  endtask

  task automatic test_flush_idle();
    div_en = 1'b1; flush = 1'b1; div = 2'd1; dividend = 32'd9; divisor = 32'd3;
    step();
    div_en = 1'b0; flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle busy: got %b want 0", busy);
    end
    step();
    vectors++;
    if (busy !== 1'b0 || div_done !== 1'b0) begin
      errors++; $display("FAIL flush_idle later: busy=%b done=%b want 0/0", busy, div_done);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    div_en = 1'b1; div = 2'd0; dividend = 32'hFFFF_0000; divisor = 32'd13;
    step();
    div_en = 1'b0;
    for (int c = 1; c < 20; c++) step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    vectors++;
    if (busy !== 1'b0 || result !== 32'h0 || div_done !== 1'b0) begin
      errors++; $display("FAIL reset_mid: busy=%b result=%h done=%b want 0/0/0",
                         busy, result, div_done);
    end
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (div_done === 1'b1) done_cnt++;
      step();
    end
    vectors++;
    if (done_cnt !== 0) begin
      errors++; $display("FAIL reset_mid stray_done: got %0d want 0", done_cnt);
    end
    run_op("after_reset", 2'd2, 32'hFFFF_FF9C, 32'd7, model(2'd2, 32'hFFFF_FF9C, 32'd7));
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, r1, r2;
    int d1, d2, n;
    a1 = $urandom; b1 = $urandom_range(1, 1000);
    a2 = $urandom; b2 = $urandom_range(1, 1000);
    div_en = 1'b1; div = 2'd1; dividend = a1; divisor = b1;
    step();
    div = 2'd3; dividend = a2; divisor = b2;
    n = 0; d1 = 0; d2 = 0; r1 = '0; r2 = '0;
    for (int c = 1; c <= 75; c++) begin
      if (div_done === 1'b1) begin
        n++;
        if (n == 1) begin d1 = c; r1 = result; end
        if (n == 2) begin d2 = c; r2 = result; div_en = 1'b0; end
      end
      step();
    end
    div_en = 1'b0;
    step();
    vectors++;
    if (d1 !== 33 || d2 !== 67) begin
      errors++; $display("FAIL back_to_back cycles: got %0d/%0d want 33/67", d1, d2);
    end
    vectors++;
    if (r1 !== model(2'd1, a1, b1)) begin
      errors++; $display("FAIL back_to_back first: got %h want %h", r1, model(2'd1, a1, b1));
    end
    vectors++;
    if (r2 !== model(2'd3, a2, b2)) begin
      errors++; $display("FAIL back_to_back second: got %h want %h", r2, model(2'd3, a2, b2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_flush();
    test_flush_idle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/divide_unit.md
# divide_unit

Iterative radix-2 divider implementing the RISC-V M-extension divide/remainder instructions (DIV, DIVU, REM, REMU). It complements the pipelined multiply unit in the execute stage. It accepts one operation per start pulse, latches operands, runs a fixed 32-iteration restoring-division loop and returns a 32-bit result with a one-cycle done pulse. Hazard logic stalls on busy.

## Interface
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset; synchronous, active-low.
- div_en  in  1  start request; accepted only in IDLE.
- flush  in  1  pipeline kill; aborts any operation in flight.
- div  in  2  op select: 0 DIV, 1 DIVU, 2 REM, 3 REMU; latched on accept.
- dividend  in  XLEN  rs1 operand; latched on accept.
- divisor  in  XLEN  rs2 operand; latched on accept.
- busy  out  1  high whenever state is not IDLE.
- div_done  out  1  one-cycle pulse; result valid in this cycle.
- result  out  XLEN  quotient or remainder; registered; holds until next completion.

## Operation
- States: IDLE, CALC, DONE. Reset: state IDLE, busy 0, div_done 0, result 0, internal registers 0.
- Accept: in IDLE with div_en=1 and flush=0, latch op, signs and operand magnitudes. Signed ops use the two's-complement magnitude; unsigned ops use the raw value. Inputs may change freely after accept.
- Special cases are detected at accept and go IDLE->DONE directly, skipping CALC:
  - divisor==0: DIV/DIVU give all ones; REM/REMU give the dividend unchanged.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- Otherwise go IDLE->CALC with a 5-bit counter at 0.
- CALC, once per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from rem using a 33-bit subtract.
  - If non-negative, commit the difference and set the quotient LSB to 1; else keep rem and set the LSB to 0.
  - Counter increments. After iteration 31 the next state is DONE.
- Entering DONE, result is registered:
  - DIV: quotient negated if the operand signs differ.
  - REM: remainder negated if the dividend is negative.
  - DIVU/REMU: raw values.
- DONE: div_done=1 for exactly this cycle, then unconditionally to IDLE. div_en in DONE is ignored.
- div_en while busy is ignored; the operation in flight is undisturbed.
- flush=1 in CALC or DONE: next state IDLE. No div_done is generated and result is not updated. In the DONE cycle itself, div_done is already asserted and stands.
- flush and div_en together in IDLE: flush wins and nothing is accepted.
- rstn low mid-operation: all state returns to reset values the next edge, with no done pulse.

## Timing
- Normal op: accept at edge T, CALC in cycles T+1..T+32, div_done and result valid in cycle T+33. Latency is 33 cycles.
- Special case: div_done in cycle T+1.
- busy rises the cycle after accept and falls the cycle after div_done. The earliest next accept is in the cycle after div_done, giving 34 cycles per normal op back-to-back.
- result changes only on the edge entering DONE. It is stable through IDLE.
- Iteration path is one 33-bit subtract plus a mux. The sign fix-up is one negate, placed in the transition into DONE.

## Test plan
- DIVU 0xFFFFFFFF / 3, div_en pulsed at T: busy at T+1, div_done only at T+33, result 0x55555555. Repeat with REMU 7/3: result 1.
- Signed: DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIV 7/-2 gives 0xFFFFFFFD; REM 7/-2 gives 1. Each completes at T+33.
- Divide by zero: DIVU 5/0 gives 0xFFFFFFFF and REMU 5/0 gives 5, both with div_done at T+1. Overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0, at T+1.
- Ignored start and operand hold: re-pulse div_en with different operands at T+5 and change the inputs every cycle. Exactly one div_done at T+33, with the original result.
- flush at T+10: busy low at T+11, no div_done ever, result keeps its prior value. A new DIVU 100/7 accepted at T+11 gives 14 at T+44.
- rstn low at T+20 for one cycle: busy 0, result 0, div_done 0 from T+21. A fresh op then completes normally.
